// File: rtl/psum_pack.sv
// Packs a stream of fp16 partial sums lane-by-lane into LANES*LANE_W-bit FIFO words.
// Optional PSUM_PACK_CNT_EN adds word_count / pad_lanes write statistics.
module psum_pack #(
  parameter int LANES  = 8,
  parameter int LANE_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANE_W-1:0]       in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic                    flush,
  input  logic                    fifo_full,
  output logic                    writes_en,
  output logic [LANES*LANE_W-1:0] fifo_data,
  output logic                    done
`ifdef PSUM_PACK_CNT_EN
  ,
  output logic [15:0]             word_count,
  output logic [3:0]              pad_lanes
`endif
);

  localparam int CW = $clog2(LANES + 1);

  typedef enum logic {FILL, WRITE} state_t;

  state_t                    state, state_nxt;
  logic [CW-1:0]             cnt;
  logic [LANE_W-1:0]         lane_buf [LANES];
  logic [LANES*LANE_W-1:0]   buf_flat;
  logic                      close_by_last;
  logic                      accept;
  logic                      close_full;
  logic                      close_word;
  logic                      write_now;

  always_comb begin
    accept     = in_valid && in_ready;
    close_full = accept && (cnt == CW'(LANES - 1));
    // A flush with nothing buffered is dropped so no empty word is ever written.
    close_word = (state == FILL) &&
                 ((accept && (close_full || in_last || flush)) ||
                  (!accept && flush && (cnt != '0)));
    write_now  = (state == WRITE) && !fifo_full;
  end

  always_comb begin
    buf_flat = '0;
    for (int k = 0; k < LANES; k++) begin
      buf_flat[k*LANE_W +: LANE_W] = lane_buf[k];
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (close_word) state_nxt = WRITE;
      WRITE:   if (!fifo_full) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state == FILL) && !rst;
  end

  // Lane buffer fill, then one write cycle that hands the word to the FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= '0;
      close_by_last <= 1'b0;
      writes_en     <= 1'b0;
      done          <= 1'b0;
      fifo_data     <= '0;
      for (int k = 0; k < LANES; k++) lane_buf[k] <= '0;
    end else begin
      writes_en <= 1'b0;
      done      <= 1'b0;
      if (accept) begin
        for (int k = 0; k < LANES; k++) begin
          if (cnt == CW'(k)) lane_buf[k] <= in_data;
        end
        cnt <= cnt + CW'(1);
      end
      if (close_word) close_by_last <= in_last || flush;
      if (write_now) begin
        writes_en     <= 1'b1;
        fifo_data     <= buf_flat;
        done          <= close_by_last;
        cnt           <= '0;
        close_by_last <= 1'b0;
        for (int k = 0; k < LANES; k++) lane_buf[k] <= '0;
      end
    end
  end

`ifdef PSUM_PACK_CNT_EN
  // cnt still holds the filled-lane count while the word waits in WRITE
  always_ff @(posedge clk) begin
    if (rst) begin
      word_count <= '0;
      pad_lanes  <= '0;
    end else if (write_now) begin
      word_count <= word_count + 16'd1;
      pad_lanes  <= 4'(CW'(LANES) - cnt);
    end
  end
`endif

endmodule
